datapath_core: RTL and testbench

- 32-bit single-bus CPU datapath for the phase-1 processor bring-up.
- Holds:
  - general registers R1–R4
  - PC, IR, MAR, MDR
  - ALU operand latch Y
  - 64-bit result register Z
- All transfers go over one shared 32-bit bus. A control sequencer (testbench or future control unit) drives the per-register in/out strobes one clock step at a time.
- The ALU implements increment-PC, add, and rotate-left.

---
 rtl/datapath_core.sv | 142 ++++++++++++++
 tb/tb_datapath_core.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_core.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_core
//  Purpose  : 32-bit single-bus CPU datapath. Holds R1-R4, PC, IR, MAR, MDR,
//             the ALU operand latch Y and the 64-bit result register Z. All
//             register-to-register transfers go over one shared bus. An
//             external sequencer drives the in/out strobes one step at a time.
//  Ports    : clock            rising-edge clock for every register
//             clear            synchronous reset, active-low
//             Mdatain[31:0]    memory read data
//             MD_read          MDR source select (1 = Mdatain, 0 = bus)
//             *in strobes      register load enables (Zlowin loads all 64 bits)
//             *out strobes     bus source enables (fixed priority)
//             IncPC/ROL[/ROR]  ALU operation selects (IncPC > ROL > ROR > add)
//             BusMuxOut        current bus value
//             MARout_addr      MAR contents (memory address)
//             IRout_q          IR contents for the control unit
//  Options  : DATAPATH_ROR_EN  adds the ROR port and a rotate-right ALU op
//  Revision : 1.0  initial release
// ============================================================================
module datapath_core #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             MD_read,
    input  logic             MDRin,
    input  logic             MARin,
    input  logic             PCin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             Zlowin,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic             R4in,
    input  logic             MDRout,
    input  logic             PCout,
    input  logic             Zlowout,
    input  logic             R1out,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             R4out,
    input  logic             IncPC,
    input  logic             ROL,
`ifdef DATAPATH_ROR_EN
    input  logic             ROR,
`endif
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] MARout_addr,
    output logic [WIDTH-1:0] IRout_q
);

    localparam int c_SHW = $clog2(WIDTH);

    logic [WIDTH-1:0]   r_r1, r_r2, r_r3, r_r4;
    logic [WIDTH-1:0]   r_pc, r_ir, r_mar, r_mdr, r_y;
    logic [2*WIDTH-1:0] r_z;

    logic [WIDTH-1:0]   w_bus;
    logic [WIDTH-1:0]   w_mdr_d;
    logic [c_SHW-1:0]   w_shamt;
    logic [2*WIDTH-1:0] w_rot_dbl;
    logic [2*WIDTH-1:0] w_rol_ext;
    logic [2*WIDTH-1:0] w_alu;
`ifdef DATAPATH_ROR_EN
    logic [2*WIDTH-1:0] w_ror_ext;
`endif

    // Bus source select, fixed priority. Idle bus reads as zero.
    always_comb begin
        w_bus = '0;
        if (MDRout)       w_bus = r_mdr;
        else if (PCout)   w_bus = r_pc;
        else if (Zlowout) w_bus = r_z[WIDTH-1:0];
        else if (R1out)   w_bus = r_r1;
        else if (R2out)   w_bus = r_r2;
        else if (R3out)   w_bus = r_r3;
        else if (R4out)   w_bus = r_r4;
    end

    assign w_mdr_d = MD_read ? Mdatain : w_bus;

    // Rotations operate on Y concatenated with itself: a left shift leaves
    // the rotated word in the upper half, a right shift in the lower half.
    // Only B[4:0] is used, so a bus value of 32 rotates by zero.
    assign w_shamt   = w_bus[c_SHW-1:0];
    assign w_rot_dbl = {r_y, r_y};
    assign w_rol_ext = w_rot_dbl << w_shamt;
`ifdef DATAPATH_ROR_EN
    assign w_ror_ext = w_rot_dbl >> w_shamt;
`endif

    // ALU: A = Y, B = bus. The high word of Z is always zero for these ops.
    always_comb begin
        w_alu = '0;
        if (IncPC)
            w_alu[WIDTH-1:0] = w_bus + WIDTH'(1);
        else if (ROL)
            w_alu[WIDTH-1:0] = w_rol_ext[2*WIDTH-1:WIDTH];
`ifdef DATAPATH_ROR_EN
        else if (ROR)
            w_alu[WIDTH-1:0] = w_ror_ext[WIDTH-1:0];
`endif
        else
            w_alu[WIDTH-1:0] = r_y + w_bus;
    end

    // Register file. Reset overrides every load strobe in the same cycle.
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_r1  <= '0;
            r_r2  <= '0;
            r_r3  <= '0;
            r_r4  <= '0;
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_y   <= '0;
            r_z   <= '0;
        end else begin
            if (R1in)   r_r1  <= w_bus;
            if (R2in)   r_r2  <= w_bus;
            if (R3in)   r_r3  <= w_bus;
            if (R4in)   r_r4  <= w_bus;
            if (PCin)   r_pc  <= w_bus;
            if (IRin)   r_ir  <= w_bus;
            if (MARin)  r_mar <= w_bus;
            if (MDRin)  r_mdr <= w_mdr_d;
            if (Yin)    r_y   <= w_bus;
            if (Zlowin) r_z   <= w_alu;
        end
    end

    assign BusMuxOut   = w_bus;
    assign MARout_addr = r_mar;
    assign IRout_q     = r_ir;

endmodule
`default_nettype wire

// File: tb/tb_datapath_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_datapath_core
//  Purpose  : Self-checking bench for datapath_core. Expected bus values are
//             queued when a read step is issued and compared on sampling.
//  Options  : DATAPATH_ROR_EN  also exercises the rotate-right operation
//  Revision : 1.0  initial release
// ============================================================================
module tb_datapath_core;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] Mdatain;
    logic        MD_read, MDRin, MARin, PCin, IRin, Yin, Zlowin;
    logic        R1in, R2in, R3in, R4in;
    logic        MDRout, PCout, Zlowout, R1out, R2out, R3out, R4out;
    logic        IncPC, ROL;
`ifdef DATAPATH_ROR_EN
    logic        ROR;
`endif
    logic [31:0] BusMuxOut, MARout_addr, IRout_q;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    datapath_core #(.WIDTH(32)) u_dut (
        .clock       (clock),
        .clear       (clear),
        .Mdatain     (Mdatain),
        .MD_read     (MD_read),
        .MDRin       (MDRin),
        .MARin       (MARin),
        .PCin        (PCin),
        .IRin        (IRin),
        .Yin         (Yin),
        .Zlowin      (Zlowin),
        .R1in        (R1in),
        .R2in        (R2in),
        .R3in        (R3in),
        .R4in        (R4in),
        .MDRout      (MDRout),
        .PCout       (PCout),
        .Zlowout     (Zlowout),
        .R1out       (R1out),
        .R2out       (R2out),
        .R3out       (R3out),
        .R4out       (R4out),
        .IncPC       (IncPC),
        .ROL         (ROL),
`ifdef DATAPATH_ROR_EN
        .ROR         (ROR),
`endif
        .BusMuxOut   (BusMuxOut),
        .MARout_addr (MARout_addr),
        .IRout_q     (IRout_q)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    task automatic clr_strobes();
        MD_read = 0; MDRin = 0; MARin = 0; PCin = 0; IRin = 0; Yin = 0;
        Zlowin = 0; R1in = 0; R2in = 0; R3in = 0; R4in = 0;
        MDRout = 0; PCout = 0; Zlowout = 0;
        R1out = 0; R2out = 0; R3out = 0; R4out = 0;
        IncPC = 0; ROL = 0;
`ifdef DATAPATH_ROR_EN
        ROR = 0;
`endif
    endtask

    // Apply the currently driven strobes at one rising edge, then drop them.
    task automatic step();
        @(posedge clock);
        #1;
        clr_strobes();
    endtask

    // Queue the expected bus value for the out-strobes already driven,
    // let the bus settle, then pop and compare.
    task automatic read_bus(input string tag, input logic [31:0] expv);
        logic [31:0] e;
        string       t;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_value(t, BusMuxOut, e);
        clr_strobes();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; MD_read = 1; MDRin = 1;
        step();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v);
        MDRout = 1; Yin = 1;
        step();
    endtask

    // Y must already hold the rotate source; MDR supplies the bus operand.
    task automatic alu_to_z(input logic [31:0] b, input logic inc,
                            input logic rol);
        load_mdr(b);
        MDRout = 1; IncPC = inc; ROL = rol; Zlowin = 1;
        step();
    endtask

    initial begin
        clr_strobes();
        Mdatain = '0;
        clear   = 1'b0;
        step();
        clear   = 1'b1;

        // ---- make everything nonzero, then reset with loads pending ----
        load_y(32'hA5A5_A5A5);
        MDRout = 1; R1in = 1; R2in = 1; R3in = 1; R4in = 1;
        PCin = 1; IRin = 1; MARin = 1; Zlowin = 1;
        step();
        check_value("pre_mar", MARout_addr, 32'hA5A5_A5A5);
        check_value("pre_ir",  IRout_q,     32'hA5A5_A5A5);
        Zlowout = 1;
        read_bus("pre_z", 32'h4B4B_4B4A);

        clear = 1'b0;
        MDRout = 1; R1in = 1; PCin = 1; MARin = 1; Yin = 1;
        step();
        clear = 1'b1;
        check_value("rst_mar", MARout_addr, 32'h0);
        check_value("rst_ir",  IRout_q,     32'h0);
        read_bus("rst_idle_bus", 32'h0);
        PCout   = 1; read_bus("rst_pc",  32'h0);
        MDRout  = 1; read_bus("rst_mdr", 32'h0);
        Zlowout = 1; read_bus("rst_z",   32'h0);
        R1out   = 1; read_bus("rst_r1",  32'h0);
        R2out   = 1; read_bus("rst_r2",  32'h0);
        R3out   = 1; read_bus("rst_r3",  32'h0);
        R4out   = 1; read_bus("rst_r4",  32'h0);
        Zlowin  = 1; step();                      // Z = Y + idle bus
        Zlowout = 1; read_bus("rst_y", 32'h0);

        // ---- PC increment (PC is 0 after reset) ----
        PCout = 1; MARin = 1; IncPC = 1; Zlowin = 1;
        step();
        Zlowout = 1; PCin = 1;
        step();
        PCout = 1; read_bus("pc_inc", 32'h1);
        check_value("pc_inc_mar", MARout_addr, 32'h0);

        // ---- register loads through MDR ----
        load_mdr(32'hF000_0012); MDRout = 1; R2in = 1; step();
        load_mdr(32'h0000_0008); MDRout = 1; R3in = 1; step();
        load_mdr(32'h0000_0018); MDRout = 1; R1in = 1; step();
        R2out = 1; read_bus("ld_r2", 32'hF000_0012);
        R3out = 1; read_bus("ld_r3", 32'h0000_0008);
        R1out = 1; read_bus("ld_r1", 32'h0000_0018);
        Mdatain = 32'hDEAD_BEEF; MD_read = 1;     // no MDRin: MDR holds
        step();
        MDRout = 1; read_bus("mdread_only", 32'h0000_0018);

        // ---- rotate R2 by R3 into R1 ----
        R2out = 1; Yin = 1; step();
        R3out = 1; ROL = 1; Zlowin = 1; step();
        Zlowout = 1; R1in = 1; step();
        R1out = 1; read_bus("rol_r1", 32'h0000_12F0);

        // ---- rotate boundaries ----
        load_y(32'h8000_0001);
        alu_to_z(32'h1, 0, 1);
        Zlowout = 1; read_bus("rol_1", 32'h0000_0003);
        alu_to_z(32'h20, 0, 1);
        Zlowout = 1; read_bus("rol_32", 32'h8000_0001);
        alu_to_z(32'h1F, 0, 1);
        Zlowout = 1; read_bus("rol_31", 32'hC000_0000);

        // ---- add with carry out discarded ----
        load_y(32'hFFFF_FFFF);
        load_mdr(32'h2); MDRout = 1; R4in = 1; step();
        R4out = 1; Zlowin = 1; step();
        Zlowout = 1; read_bus("add_wrap", 32'h0000_0001);

        // ---- bus priority, simultaneous and self loads ----
        load_mdr(32'h1234_5678);
        MDRout = 1; R4out = 1; read_bus("prio_mdr_r4", 32'h1234_5678);
        R1out = 1; R2out = 1;  read_bus("prio_r1_r2",  32'h0000_12F0);
        PCout = 1; Zlowout = 1; read_bus("prio_pc_z",  32'h0000_0001);
        R1out = 1; R1in = 1; step();
        R1out = 1; read_bus("self_load", 32'h0000_12F0);
        MDRout = 1; R3in = 1; R4in = 1; step();
        R3out = 1; read_bus("multi_r3", 32'h1234_5678);
        R4out = 1; read_bus("multi_r4", 32'h1234_5678);

        // ---- op priority and increment wrap ----
        alu_to_z(32'h1234_5678, 1, 1);
        Zlowout = 1; read_bus("inc_over_rol", 32'h1234_5679);
        alu_to_z(32'hFFFF_FFFF, 1, 0);
        Zlowout = 1; read_bus("inc_wrap", 32'h0000_0000);

`ifdef DATAPATH_ROR_EN
        load_y(32'h8000_0001);
        load_mdr(32'h1); MDRout = 1; ROR = 1; Zlowin = 1; step();
        Zlowout = 1; read_bus("ror_1", 32'hC000_0000);
        load_mdr(32'h1); MDRout = 1; ROL = 1; ROR = 1; Zlowin = 1; step();
        Zlowout = 1; read_bus("rol_over_ror", 32'h0000_0003);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
